// File: rtl/sata_rx_prim_dec_if.sv
// ============================================================================
// sata_rx_prim_dec_if : PHY-side dword stream and decoded outputs of the
//                       SATA receive primitive decoder.  Rev 1.0
// ============================================================================
`default_nettype none

interface sata_rx_prim_dec_if #(
  parameter int C_STAT_W = 16
);
  logic                linkup;
  logic [31:0]         rxdata;
  logic                rxdatak;
  logic                stats_clr;
  logic                prim_valid;
  logic [4:0]          prim_code;
  logic                data_valid;
  logic [31:0]         data_out;
  logic                sof;
  logic                eof;
  logic                align_seen;
  logic                cont_err;
  logic                frame_err;
  logic [C_STAT_W-1:0] cnt_unknown;
  logic [C_STAT_W-1:0] cnt_cont_err;
  logic [C_STAT_W-1:0] cnt_frame_err;

  modport master (
    output linkup, rxdata, rxdatak, stats_clr,
    input  prim_valid, prim_code, data_valid, data_out, sof, eof,
           align_seen, cont_err, frame_err,
           cnt_unknown, cnt_cont_err, cnt_frame_err
  );

  modport slave (
    input  linkup, rxdata, rxdatak, stats_clr,
    output prim_valid, prim_code, data_valid, data_out, sof, eof,
           align_seen, cont_err, frame_err,
           cnt_unknown, cnt_cont_err, cnt_frame_err
  );
endinterface

`default_nettype wire

// File: rtl/sata_rx_prim_dec.sv
// ============================================================================
// sata_rx_prim_dec : classifies received dwords, strips ALIGN, expands CONT,
//                    delimits SOF..EOF frames. Counters: SATA_RX_PRIM_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module sata_rx_prim_dec #(
  parameter int C_STAT_W = 16
) (
  input  wire                   phyclk,
  input  wire                   phyreset_n,
  sata_rx_prim_dec_if.slave     bus
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } frame_st_e;

  localparam logic [4:0] P_NONE  = 5'd0;
  localparam logic [4:0] P_ALIGN = 5'd1;
  localparam logic [4:0] P_CONT  = 5'd2;
  localparam logic [4:0] P_EOF   = 5'd4;
  localparam logic [4:0] P_SOF   = 5'd15;
  localparam logic [4:0] P_SYNC  = 5'd16;
  localparam logic [4:0] P_UNK   = 5'd31;

  logic [4:0]  code_w;

  frame_st_e   st_q, st_d;
  logic        supp_q, supp_d;
  logic [1:0]  rep_q, rep_d;
  logic [4:0]  last_q, last_d;

  logic        pv_q, pv_d;
  logic [4:0]  pc_q, pc_d;
  logic        dv_q, dv_d;
  logic [31:0] dout_q, dout_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic        align_q, align_d;
  logic        cerr_q, cerr_d;
  logic        ferr_q, ferr_d;

  always_comb begin
    code_w = P_NONE;
    if (bus.rxdatak) begin
      case (bus.rxdata)
        32'h7B4A4ABC: code_w = 5'd1;
        32'h9999AA7C: code_w = 5'd2;
        32'h3636B57C: code_w = 5'd3;
        32'hD5D5B57C: code_w = 5'd4;
        32'hD5D5AA7C: code_w = 5'd5;
        32'h9595AA7C: code_w = 5'd6;
        32'h9595957C: code_w = 5'd7;
        32'hF5F5957C: code_w = 5'd8;
        32'h1717B57C: code_w = 5'd9;
        32'h7575957C: code_w = 5'd10;
        32'h5656B57C: code_w = 5'd11;
        32'h5555B57C: code_w = 5'd12;
        32'h3535B57C: code_w = 5'd13;
        32'h4A4A957C: code_w = 5'd14;
        32'h3737B57C: code_w = 5'd15;
        32'hB5B5957C: code_w = 5'd16;
        32'h5858B57C: code_w = 5'd17;
        32'h5757B57C: code_w = 5'd18;
        default:      code_w = P_UNK;
      endcase
    end
  end

  always_comb begin
    st_d    = st_q;
    supp_d  = supp_q;
    rep_d   = rep_q;
    last_d  = last_q;
    pv_d    = 1'b0;
    pc_d    = P_NONE;
    dv_d    = 1'b0;
    dout_d  = 32'd0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    align_d = 1'b0;
    cerr_d  = 1'b0;
    ferr_d  = 1'b0;

    if (!bus.linkup) begin
      st_d   = ST_IDLE;
      supp_d = 1'b0;
      rep_d  = 2'd0;
      last_d = P_NONE;
    end else if (code_w == P_ALIGN) begin
      align_d = 1'b1;
    end else if (supp_q && (!bus.rxdatak || code_w == P_CONT)) begin
      // scrambled filler and further CONTs keep replaying the suppressed primitive
      pv_d = 1'b1;
      pc_d = last_q;
    end else begin
      supp_d = 1'b0;
      if (!bus.rxdatak) begin
        rep_d = 2'd0;
        if (st_q == ST_FRAME) begin
          dv_d   = 1'b1;
          dout_d = bus.rxdata;
        end else begin
          ferr_d = 1'b1;
        end
      end else if (code_w == P_CONT) begin
        pv_d = 1'b1;
        if (rep_q == 2'd2 && last_q != P_UNK) begin
          supp_d = 1'b1;
          pc_d   = last_q;
        end else begin
          pc_d   = P_CONT;
          cerr_d = 1'b1;
        end
      end else begin
        pv_d   = 1'b1;
        pc_d   = code_w;
        last_d = code_w;
        if (code_w == last_q && rep_q != 2'd0)
          rep_d = (rep_q == 2'd2) ? 2'd2 : rep_q + 2'd1;
        else
          rep_d = 2'd1;
        case (code_w)
          P_SOF: begin
            sof_d  = 1'b1;
            ferr_d = (st_q == ST_FRAME);
            st_d   = ST_FRAME;
          end
          P_EOF: begin
            if (st_q == ST_FRAME) begin
              eof_d = 1'b1;
              st_d  = ST_IDLE;
            end else begin
              ferr_d = 1'b1;
            end
          end
          P_SYNC:  st_d = ST_IDLE;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge phyclk or negedge phyreset_n) begin
    if (!phyreset_n) begin
      st_q    <= ST_IDLE;
      supp_q  <= 1'b0;
      rep_q   <= 2'd0;
      last_q  <= P_NONE;
      pv_q    <= 1'b0;
      pc_q    <= P_NONE;
      dv_q    <= 1'b0;
      dout_q  <= 32'd0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      align_q <= 1'b0;
      cerr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      st_q    <= st_d;
      supp_q  <= supp_d;
      rep_q   <= rep_d;
      last_q  <= last_d;
      pv_q    <= pv_d;
      pc_q    <= pc_d;
      dv_q    <= dv_d;
      dout_q  <= dout_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      align_q <= align_d;
      cerr_q  <= cerr_d;
      ferr_q  <= ferr_d;
    end
  end

  assign bus.prim_valid = pv_q;
  assign bus.prim_code  = pc_q;
  assign bus.data_valid = dv_q;
  assign bus.data_out   = dout_q;
  assign bus.sof        = sof_q;
  assign bus.eof        = eof_q;
  assign bus.align_seen = align_q;
  assign bus.cont_err   = cerr_q;
  assign bus.frame_err  = ferr_q;

`ifdef SATA_RX_PRIM_STATS_EN
  localparam logic [C_STAT_W-1:0] C_STAT_ONE = C_STAT_W'(1);

  logic [C_STAT_W-1:0] cnt_unk_q, cnt_cerr_q, cnt_ferr_q;
  logic                unk_evt_w;

  assign unk_evt_w = pv_d && (pc_d == P_UNK);

  // counters advance in step with the pulse they count; clear has priority
  always_ff @(posedge phyclk or negedge phyreset_n) begin
    if (!phyreset_n) begin
      cnt_unk_q  <= '0;
      cnt_cerr_q <= '0;
      cnt_ferr_q <= '0;
    end else if (bus.stats_clr) begin
      cnt_unk_q  <= '0;
      cnt_cerr_q <= '0;
      cnt_ferr_q <= '0;
    end else begin
      if (unk_evt_w && !(&cnt_unk_q))
        cnt_unk_q <= cnt_unk_q + C_STAT_ONE;
      if (cerr_d && !(&cnt_cerr_q))
        cnt_cerr_q <= cnt_cerr_q + C_STAT_ONE;
      if (ferr_d && !(&cnt_ferr_q))
        cnt_ferr_q <= cnt_ferr_q + C_STAT_ONE;
    end
  end

  assign bus.cnt_unknown   = cnt_unk_q;
  assign bus.cnt_cont_err  = cnt_cerr_q;
  assign bus.cnt_frame_err = cnt_ferr_q;
`else
  assign bus.cnt_unknown   = '0;
  assign bus.cnt_cont_err  = '0;
  assign bus.cnt_frame_err = '0;
`endif

endmodule

`default_nettype wire
